// File: rtl/sequenciador_ula.sv
// sequenciador_ula: issue/writeback sequencer in front of the ULA.
// Accepts one operation at a time, drives ulaOP/RS/RT into the ULA and captures
// its registered result. Divide-by-zero, illegal opcodes and HI/LO reads are
// resolved locally without ever reaching the ULA.
module sequenciador_ula #(
  parameter int LARG = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      op_in,
  input  logic [LARG-1:0] a_in,
  input  logic [LARG-1:0] b_in,
  output logic [4:0]      ulaOP,
  output logic [LARG-1:0] RS,
  output logic [LARG-1:0] RT,
  input  logic [LARG-1:0] saidaULA,
  input  logic [LARG-1:0] saidaHI,
  input  logic [LARG-1:0] saidaLO,
  output logic            busy,
  output logic            done,
  output logic [LARG-1:0] resultado,
  output logic [LARG-1:0] hi,
  output logic [LARG-1:0] lo,
  output logic            erro
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_REM  = 5'b00100;
  localparam logic [4:0] OP_XNOR = 5'b01011;
  localparam logic [4:0] OP_RHI  = 5'b01100;
  localparam logic [4:0] OP_RLO  = 5'b01101;
  localparam logic [4:0] OP_GT   = 5'b01110;
  localparam logic [4:0] OP_PASS = 5'b11111;

  // Codes the ULA itself implements: 00000..01011, greater-than and pass-RT.
  function automatic logic is_fwd(input logic [4:0] op);
    return (op <= OP_XNOR) || (op == OP_GT) || (op == OP_PASS);
  endfunction

  logic [1:0]      state_r, state_s;
  logic [4:0]      ulaop_r, ulaop_s;
  logic [LARG-1:0] rs_r, rs_s, rt_r, rt_s;
  logic [LARG-1:0] res_r, res_s, hi_r, hi_s, lo_r, lo_s;
  logic            erro_r, erro_s, busy_r, busy_s, done_r, done_s;
  logic            accept_s, fwd_s, divzero_s, local_s;

  assign accept_s  = start && ((state_r == S_IDLE) || (state_r == S_DONE));
  assign fwd_s     = is_fwd(op_in);
  assign divzero_s = ((op_in == OP_DIV) || (op_in == OP_REM)) && (b_in == '0);
  assign local_s   = (op_in == OP_RHI) || (op_in == OP_RLO);

  // State register; reset wins over any pending request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; DONE accepts a new request exactly like IDLE.
  always_comb begin
    state_s = S_IDLE;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          if (fwd_s && !divzero_s) begin
            state_s = S_ISSUE;
          end else begin
            state_s = S_DONE;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: state_s = S_WAIT;
      S_WAIT:  state_s = S_DONE;
      default: state_s = S_IDLE;
    endcase
  end

  // Next values of every output register; flags follow the next state so that
  // busy/done line up with ISSUE/WAIT and DONE without a combinational path.
  always_comb begin
    ulaop_s = ulaop_r;
    rs_s    = rs_r;
    rt_s    = rt_r;
    res_s   = res_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    erro_s  = erro_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          if (fwd_s && !divzero_s) begin
            ulaop_s = op_in;
            rs_s    = a_in;
            rt_s    = b_in;
          end else if (local_s) begin
            res_s  = (op_in == OP_RHI) ? hi_r : lo_r;
            erro_s = 1'b0;
          end else begin
            res_s  = '0;
            erro_s = 1'b1;
          end
        end else begin
          res_s = res_r;
        end
      end
      S_WAIT: begin
        res_s  = saidaULA;
        erro_s = 1'b0;
        if (ulaop_r == OP_MUL) begin
          hi_s = saidaHI;
          lo_s = saidaLO;
        end else begin
          hi_s = hi_r;
          lo_s = lo_r;
        end
        ulaop_s = OP_PASS;
        rs_s    = '0;
        rt_s    = '0;
      end
      default: begin
        ulaop_s = ulaop_r;
      end
    endcase
    busy_s = (state_s == S_ISSUE) || (state_s == S_WAIT);
    done_s = (state_s == S_DONE);
  end

  // Output registers with their reset values.
  always_ff @(posedge clock) begin
    if (reset) begin
      ulaop_r <= OP_PASS;
      rs_r    <= '0;
      rt_r    <= '0;
      res_r   <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      erro_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      ulaop_r <= ulaop_s;
      rs_r    <= rs_s;
      rt_r    <= rt_s;
      res_r   <= res_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      erro_r  <= erro_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign ulaOP     = ulaop_r;
  assign RS        = rs_r;
  assign RT        = rt_r;
  assign resultado = res_r;
  assign hi        = hi_r;
  assign lo        = lo_r;
  assign erro      = erro_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_sequenciador_ula.sv
// Directed bench for sequenciador_ula with a behavioural registered ULA and a
// scoreboard of expected completions.
module tb_sequenciador_ula;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [4:0]  op_in;
  logic [31:0] a_in, b_in;
  logic [4:0]  ulaOP;
  logic [31:0] RS, RT, saidaULA, saidaHI, saidaLO;
  logic        busy, done, erro;
  logic [31:0] resultado, hi, lo;

  typedef struct packed {
    logic [31:0] res;
    logic        err;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  sequenciador_ula #(.LARG(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op_in(op_in),
    .a_in(a_in), .b_in(b_in), .ulaOP(ulaOP), .RS(RS), .RT(RT),
    .saidaULA(saidaULA), .saidaHI(saidaHI), .saidaLO(saidaLO),
    .busy(busy), .done(done), .resultado(resultado), .hi(hi), .lo(lo),
    .erro(erro)
  );

  always #5 clock = ~clock;

  // Behavioural ULA: registered outputs computed from ulaOP/RS/RT.
  logic [63:0] prod;
  assign prod = {32'd0, RS} * {32'd0, RT};
  always_ff @(posedge clock) begin
    saidaHI <= prod[63:32];
    saidaLO <= prod[31:0];
    case (ulaOP)
      5'b00000: saidaULA <= RS + RT;
      5'b00001: saidaULA <= RS - RT;
      5'b00010: saidaULA <= prod[31:0];
      5'b00011: saidaULA <= (RT == 32'd0) ? 32'd0 : RS / RT;
      5'b00100: saidaULA <= (RT == 32'd0) ? 32'd0 : RS % RT;
      5'b00101: saidaULA <= RS | RT;
      5'b00110: saidaULA <= RS & RT;
      5'b00111: saidaULA <= ~RS;
      5'b01000: saidaULA <= RS ^ RT;
      5'b01001: saidaULA <= ~(RS | RT);
      5'b01010: saidaULA <= ~(RS & RT);
      5'b01011: saidaULA <= ~(RS ^ RT);
      5'b01110: saidaULA <= (RS > RT) ? 32'd1 : 32'd0;
      5'b11111: saidaULA <= RT;
      default:  saidaULA <= 32'd0;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] r, input logic e, input logic [31:0] h, input logic [31:0] l);
    exp_t x;
    x.res = r; x.err = e; x.hi = h; x.lo = l;
    sb.push_back(x);
  endtask

  // Called at a negedge after the accept edge; returns at the negedge where done=1.
  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
    int   lat = 1;
    int   nb = 0;
    exp_t x;
    while (done !== 1'b1 && lat < 12) begin
      if (busy === 1'b1) nb++;
      @(negedge clock);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " busy cycles"}, 32'(nb), 32'(exp_busy));
    chk({tag, " busy at done"}, {31'd0, busy}, 32'd0);
    vectors++;
    assert (sb.size() != 0) else begin
      miscompares++;
      $error("FAIL %s scoreboard: observed empty queue expected entry", tag);
    end
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk({tag, " resultado"}, resultado, x.res);
      chk({tag, " erro"}, {31'd0, erro}, {31'd0, x.err});
      chk({tag, " hi"}, hi, x.hi);
      chk({tag, " lo"}, lo, x.lo);
    end
  endtask

  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input int exp_busy);
    @(negedge clock);
    start = 1'b1; op_in = op; a_in = a; b_in = b;
    @(negedge clock);
    start = 1'b0;
    wait_done(tag, exp_lat, exp_busy);
  endtask

  initial begin
    int seen_done;
    reset = 1'b1; start = 1'b0; op_in = 5'd0; a_in = 32'd0; b_in = 32'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset ulaOP", {27'd0, ulaOP}, 32'h1f);
    chk("reset RS", RS, 32'd0);
    chk("reset RT", RT, 32'd0);
    chk("reset flags", {29'd0, busy, done, erro}, 32'd0);
    chk("reset resultado", resultado, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);

    push(32'd12, 1'b0, 32'd0, 32'd0);
    do_op("add", 5'b00000, 32'd7, 32'd5, 3, 2);

    push(32'd0, 1'b0, 32'h2, 32'h0);
    do_op("mul", 5'b00010, 32'h0001_0000, 32'h0002_0000, 3, 2);
    push(32'd2, 1'b0, 32'h2, 32'h0);
    do_op("rdhi", 5'b01100, 32'd0, 32'd0, 1, 0);
    push(32'd0, 1'b0, 32'h2, 32'h0);
    do_op("rdlo", 5'b01101, 32'd0, 32'd0, 1, 0);

    push(32'd0, 1'b1, 32'h2, 32'h0);
    do_op("div0", 5'b00011, 32'd9, 32'd0, 1, 0);
    chk("div0 ulaOP", {27'd0, ulaOP}, 32'h1f);
    push(32'd0, 1'b1, 32'h2, 32'h0);
    do_op("rem0", 5'b00100, 32'd9, 32'd0, 1, 0);
    chk("rem0 ulaOP", {27'd0, ulaOP}, 32'h1f);
    push(32'd4, 1'b0, 32'h2, 32'h0);
    do_op("div", 5'b00011, 32'd9, 32'd2, 3, 2);

    push(32'd0, 1'b1, 32'h2, 32'h0);
    do_op("illegal", 5'b10000, 32'd1, 32'd2, 1, 0);
    chk("illegal ulaOP", {27'd0, ulaOP}, 32'h1f);
    push(32'd1, 1'b0, 32'h2, 32'h0);
    do_op("gt", 5'b01110, 32'd5, 32'd3, 3, 2);

    // Back-to-back with start held; op change while busy must be ignored.
    push(32'd7, 1'b0, 32'h2, 32'h0);
    push(32'hF0, 1'b0, 32'h2, 32'h0);
    @(negedge clock);
    start = 1'b1; op_in = 5'b00001; a_in = 32'd10; b_in = 32'd3;
    @(negedge clock);
    chk("b2b issue ulaOP", {27'd0, ulaOP}, 32'h01);
    op_in = 5'b01000; a_in = 32'hFF; b_in = 32'h0F;
    wait_done("b2b sub", 3, 2);
    @(negedge clock);
    start = 1'b0;
    chk("b2b second ulaOP", {27'd0, ulaOP}, 32'h08);
    wait_done("b2b xor", 3, 2);

    // Reset during WAIT of a multiply.
    @(negedge clock);
    start = 1'b1; op_in = 5'b00010; a_in = 32'd3; b_in = 32'd5;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("rst wait busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst flags", {29'd0, busy, done, erro}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst resultado", resultado, 32'd0);
    chk("rst ulaOP", {27'd0, ulaOP}, 32'h1f);
    chk("rst RS", RS, 32'd0);
    seen_done = 0;
    repeat (4) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    chk("rst no done", 32'(seen_done), 32'd0);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sequenciador_ula.md
# sequenciador_ula

Issue/writeback sequencer on the processor side of the ULA interface. It accepts one ALU operation at a time from the control unit, drives `ulaOP`/`RS`/`RT` into the ULA, and waits for the ULA's registered output. It captures `saidaULA`/`saidaHI`/`saidaLO` into architectural result, HI and LO registers, and reports completion with a one-cycle `done` pulse. It also handles what the ULA cannot: divide-by-zero, unsupported opcodes, and HI/LO reads.

## Interface
Parameters:
- `LARG`, 32, datapath width (RS/RT/results/HI/LO).

Ports:
- `clock`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op_in`  in  5  operation code (ULA encoding, plus local codes below).
- `a_in`  in  LARG  first operand.
- `b_in`  in  LARG  second operand.
- `ulaOP`  out  5  opcode to ULA (registered).
- `RS`  out  LARG  operand A to ULA (registered).
- `RT`  out  LARG  operand B to ULA (registered).
- `saidaULA`  in  LARG  ULA main result (registered inside ULA).
- `saidaHI`  in  LARG  ULA product high word.
- `saidaLO`  in  LARG  ULA product low word.
- `busy`  out  1  operation in flight (ISSUE or WAIT).
- `done`  out  1  one-cycle completion pulse.
- `resultado`  out  LARG  result, valid while `done`=1 and held until the next completion.
- `hi`, `lo`  out  LARG  architectural HI/LO registers.
- `erro`  out  1  set with `done` for divide-by-zero or an illegal opcode.

## Operation
- ULA codes forwarded: 00000 add, 00001 sub, 00010 mul, 00011 div, 00100 rem, 00101 or, 00110 and, 00111 not, 01000 xor, 01001 nor, 01010 nand, 01011 xnor, 01110 greater-than, 11111 pass-RT.
- Local codes (no ULA issue): 01100 = read HI, 01101 = read LO.
- All other codes are illegal.
- Reset: state IDLE; `ulaOP`=11111; `RS`=`RT`=0; `busy`=`done`=`erro`=0; `resultado`=`hi`=`lo`=0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, `start`=1, at the sampling edge:
  - Forwarded op with a valid divisor: latch `op_in`/`a_in`/`b_in` into `ulaOP`/`RS`/`RT`; go to ISSUE.
  - Div or rem with `b_in`=0: no issue; `resultado`=0, `erro`=1; go to DONE.
  - Illegal code: no issue; `resultado`=0, `erro`=1; go to DONE.
  - 01100/01101: `resultado`=`hi`/`lo`, `erro`=0; go to DONE.
- ISSUE: operands and opcode are stable; the ULA samples them at the end of the cycle; go to WAIT.
- WAIT: `saidaULA` is valid. At the edge:
  - `resultado`←`saidaULA`, `erro`←0.
  - If `ulaOP`=00010, also `hi`←`saidaHI` and `lo`←`saidaLO`.
  - Restore `ulaOP`←11111 and `RS`←`RT`←0.
  - Go to DONE.
- DONE: `done`=1 for exactly this cycle. `start` is accepted here exactly as in IDLE, allowing back-to-back operations. Otherwise go to IDLE.
- `start` in ISSUE/WAIT is ignored; there is no queueing.
- `hi`/`lo` change only on multiply completion or reset. Div/rem never write HI/LO.
- Arithmetic is performed by the ULA. This block performs no width changes; values pass through at LARG bits.

## Timing
- Forwarded op accepted at edge E0:
  - ISSUE during E0→E1, WAIT during E1→E2.
  - `resultado`/`done` valid in the cycle after E2.
  - Latency: 3 edges from accept to `done` high.
- Local, illegal and divide-by-zero ops: `done` high in the cycle after the accept edge (1-edge latency).
- `busy`=1 exactly in ISSUE and WAIT.
- `done` and `busy` are never both 1.
- Throughput: one forwarded op per 3 cycles when `start` is held high.
- Reset mid-operation (ISSUE/WAIT/DONE): next state IDLE with reset values; no `done`; HI/LO cleared.
- Reset has priority over `start`.
- All outputs are registered; there is no combinational path from `start`/`op_in` to any output.

## Test plan
- Reset then add: `op_in`=00000, `a_in`=7, `b_in`=5, with a behavioural registered ULA model. Required: `done` 3 cycles after accept, `resultado`=12, `erro`=0, `busy` high exactly 2 cycles.
- Multiply: 0x0001_0000 × 0x0002_0000. Required: `hi`=0x0000_0002, `lo`=0, `resultado`=0. Follow with op 01100: `resultado`=2 with 1-cycle latency.
- Divide by zero: `op_in`=00011, `a_in`=9, `b_in`=0. Required: `ulaOP` stays 11111, `done`+`erro` in the next cycle, `resultado`=0, `hi`/`lo` unchanged. Repeat with 00100.
- Illegal code 10000. Required: `erro`=1, `resultado`=0, no ULA issue. Then op 01110 with 5,3: `resultado`=1, `erro`=0.
- Back-to-back: `start` held high with sub 10−3 then xor 0xFF^0x0F. Required: `resultado` 7 then 0xF0, `done` pulses 3 cycles apart. `start` during `busy` is ignored.
- Reset asserted in WAIT of a multiply. Required: next cycle IDLE, `hi`=`lo`=`resultado`=0, no `done` pulse.
